// File: rtl/centroid_pkg.sv
// Shared widths, quotient slice positions and FSM state encoding for the
// centroid divider scheduler.
package centroid_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int Q_MSB  = 63;
  localparam int Q_LSB  = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_X = 3'd1,
    ISSUE_Y = 3'd2,
    COLLECT = 3'd3,
    HOLD    = 3'd4,
    FLUSH   = 3'd5
  } state_e;

endpackage

// File: rtl/div_rst_stretch.sv
// Holds the divider's active-low reset for RST_HOLD cycles after the block
// reset or after a flush request; ready reports that the divider is usable.
module div_rst_stretch #(
  parameter int RST_HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_req,
  output logic div_aresetn,
  output logic ready
);

  localparam int            CW       = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_VAL = CW'(RST_HOLD);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_req)
      cnt_d = HOLD_VAL;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= HOLD_VAL;
    else     cnt_q <= cnt_d;
  end

  // rst gates the output directly so the divider is held even before the
  // first clock edge of a reset, and also for RST_HOLD = 0.
  assign ready       = !rst && (cnt_q == '0);
  assign div_aresetn = ready;

endmodule

// File: rtl/centroid_div_sched.sv
// Issues sum_x/count and sum_y/count to a shared pipelined divider and
// collects both quotients in order. Define DIV_TIMEOUT_EN to enable the
// response timeout with divider flush.
module centroid_div_sched
  import centroid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MIN_COUNT      = 1,
  parameter int RST_HOLD       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_done,
  input  logic [DATA_W-1:0] sum_x,
  input  logic [DATA_W-1:0] sum_y,
  input  logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  output logic              div_in_valid,
  input  logic              div_in_ready,
  input  logic [RES_W-1:0]  div_out_data,
  input  logic              div_out_valid,
  output logic              div_aresetn,
  output logic [DATA_W-1:0] xdiv,
  output logic [DATA_W-1:0] ydiv,
  output logic              xdiv_valid,
  output logic              ydiv_valid,
  output logic              busy,
  output logic              zero_cnt,
  output logic              timeout
);

  localparam logic [DATA_W-1:0] MIN_CNT = DATA_W'(MIN_COUNT);
  localparam logic [DATA_W-1:0] TMO_LIM = DATA_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic              acc_q;
  logic [DATA_W-1:0] sx_q, sx_d, sy_q, sy_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] xdiv_q, xdiv_d, ydiv_q, ydiv_d;
  logic [1:0]        rcv_q, rcv_d;
  logic              vld_q, vld_d, busy_q, busy_d, zero_q, zero_d;
  logic              flush_req, div_ready;
  logic [DATA_W-1:0] quot;
  logic              unused_lo_bits;

  assign quot           = div_out_data[Q_MSB:Q_LSB];
  assign unused_lo_bits = ^div_out_data[Q_LSB-1:0];

`ifdef DIV_TIMEOUT_EN
  logic [DATA_W-1:0] tmo_cnt_q, tmo_cnt_d, xold_q, xold_d, yold_q, yold_d;
  logic              tmo_q, tmo_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_LIM;
`endif

  div_rst_stretch #(.RST_HOLD(RST_HOLD)) u_rst_stretch (
    .clk         (clk),
    .rst         (rst),
    .flush_req   (flush_req),
    .div_aresetn (div_aresetn),
    .ready       (div_ready)
  );

  // NOTE: every next-state value gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    cnt_d     = cnt_q;
    xdiv_d    = xdiv_q;
    ydiv_d    = ydiv_q;
    rcv_d     = rcv_q;
    vld_d     = vld_q;
    busy_d    = busy_q;
    zero_d    = zero_q;
    flush_req = 1'b0;
`ifdef DIV_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
    xold_d    = xold_q;
    yold_d    = yold_q;
`endif

    case (state_q)
      IDLE: begin
        if (acc_done && !acc_q && div_ready) begin
          sx_d   = sum_x;
          sy_d   = sum_y;
          cnt_d  = count;
          busy_d = 1'b1;
          rcv_d  = 2'd0;
          if (count < MIN_CNT) begin
            zero_d  = 1'b1;
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = ISSUE_X;
`ifdef DIV_TIMEOUT_EN
            tmo_cnt_d = '0;
            xold_d    = xdiv_q;
            yold_d    = ydiv_q;
`endif
          end
        end
      end
      ISSUE_X: if (div_in_ready) state_d = ISSUE_Y;
      ISSUE_Y: if (div_in_ready) state_d = COLLECT;
      COLLECT: begin
        if (div_out_valid) begin
          if (rcv_q == 2'd0) begin
            xdiv_d = quot;
            rcv_d  = 2'd1;
          end else begin
            ydiv_d  = quot;
            rcv_d   = 2'd2;
            vld_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!acc_done) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          zero_d  = 1'b0;
          state_d = IDLE;
`ifdef DIV_TIMEOUT_EN
          tmo_d = 1'b0;
`endif
        end
      end
      FLUSH:   if (div_ready) state_d = HOLD;
      default: state_d = IDLE;
    endcase

`ifdef DIV_TIMEOUT_EN
    // Timeout overrides whatever the wait states decided, including a first
    // quotient already written to xdiv.
    if (state_q inside {ISSUE_X, ISSUE_Y, COLLECT}) begin
      tmo_cnt_d = tmo_cnt_q + DATA_W'(1);
      if (tmo_cnt_d == TMO_LIM) begin
        tmo_d     = 1'b1;
        flush_req = 1'b1;
        xdiv_d    = xold_q;
        ydiv_d    = yold_q;
        vld_d     = 1'b0;
        state_d   = FLUSH;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      cnt_q   <= '0;
      xdiv_q  <= '0;
      ydiv_q  <= '0;
      rcv_q   <= 2'd0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_done;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
      xdiv_q  <= xdiv_d;
      ydiv_q  <= ydiv_d;
      rcv_q   <= rcv_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
    end
  end

`ifdef DIV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
      xold_q    <= '0;
      yold_q    <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      xold_q    <= xold_d;
      yold_q    <= yold_d;
    end
  end
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign div_in_valid = (state_q == ISSUE_X) || (state_q == ISSUE_Y);
  assign div_dividend = (state_q == ISSUE_Y) ? sy_q : sx_q;
  assign div_divisor  = cnt_q;
  assign xdiv         = xdiv_q;
  assign ydiv         = ydiv_q;
  assign xdiv_valid   = vld_q;
  assign ydiv_valid   = vld_q;
  assign busy         = busy_q;
  assign zero_cnt     = zero_q;

endmodule

// File: tb/tb_centroid_div_sched.sv
// Directed bench for centroid_div_sched with an 8-cycle pipelined divider
// model; the timeout scenario runs only when DIV_TIMEOUT_EN is defined.
module tb_centroid_div_sched;

  localparam int LAT = 8;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst, acc_done, div_in_ready, div_in_valid, div_out_valid, div_aresetn;
  logic [31:0] sum_x, sum_y, count, div_dividend, div_divisor, xdiv, ydiv;
  logic [63:0] div_out_data;
  logic        xdiv_valid, ydiv_valid, busy, zero_cnt, timeout;

  logic [LAT-1:0] pv = '0;
  logic [31:0]    pq [LAT];
  bit             model_en = 1'b1;

  int checks = 0;
  int errors = 0;

  centroid_div_sched #(.TIMEOUT_CYCLES(TMO), .MIN_COUNT(1), .RST_HOLD(2)) dut (
    .clk(clk), .rst(rst), .acc_done(acc_done),
    .sum_x(sum_x), .sum_y(sum_y), .count(count),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
    .div_out_data(div_out_data), .div_out_valid(div_out_valid),
    .div_aresetn(div_aresetn), .xdiv(xdiv), .ydiv(ydiv),
    .xdiv_valid(xdiv_valid), .ydiv_valid(ydiv_valid),
    .busy(busy), .zero_cnt(zero_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Divider model: quotient in the upper word, filler in the lower word.
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], div_in_valid && div_in_ready && div_aresetn};
    pq[0] <= (div_divisor != 0) ? div_dividend / div_divisor : 32'h0;
    for (int k = 1; k < LAT; k++) pq[k] <= pq[k-1];
    div_out_valid <= pv[LAT-1] && model_en;
    div_out_data  <= {pq[LAT-1], 32'hDEAD_BEEF};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_div(input string tag, input logic [31:0] sx, input logic [31:0] sy,
                         input logic [31:0] cnt, input int stall_n, input bit drop,
                         input logic [31:0] exp_x, input logic [31:0] exp_y);
    int issued = 0, beats = 0, b2 = -1, vcyc = -1, stalls = 0, stall_left;
    bit busy_bad = 0, stable_bad = 0;
    sum_x = sx; sum_y = sy; count = cnt;
    acc_done = 1'b1;
    stall_left = stall_n;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (xdiv_valid) begin vcyc = i; break; end
      if (!busy) busy_bad = 1'b1;
      div_in_ready = 1'b1;
      if (div_in_valid && issued == 1 && stall_left > 0) begin
        div_in_ready = 1'b0;
        stalls++;
        stall_left--;
        if (div_dividend !== sy || div_divisor !== cnt) stable_bad = 1'b1;
      end
      if (div_in_valid && div_in_ready) issued++;
      if (div_out_valid) begin beats++; if (beats == 2) b2 = i; end
      if (drop && beats >= 1) acc_done = 1'b0;
    end
    div_in_ready = 1'b1;
    check({tag, " done"}, 64'(vcyc >= 0), 64'd1);
    check({tag, " xdiv"}, 64'(xdiv), 64'(exp_x));
    check({tag, " ydiv"}, 64'(ydiv), 64'(exp_y));
    check({tag, " ydiv_valid"}, 64'(ydiv_valid), 64'd1);
    check({tag, " latency"}, 64'(vcyc - b2), 64'd1);
    check({tag, " issues"}, 64'(issued), 64'd2);
    check({tag, " busy held"}, 64'(busy_bad), 64'd0);
    check({tag, " zero_cnt"}, 64'(zero_cnt), 64'd0);
    check({tag, " timeout"}, 64'(timeout), 64'd0);
    if (stall_n > 0) begin
      check({tag, " stall cycles"}, 64'(stalls), 64'(stall_n));
      check({tag, " operands stable"}, 64'(stable_bad), 64'd0);
    end
    if (drop) begin
      tick();
      check({tag, " valid one cycle"}, 64'(xdiv_valid), 64'd0);
      check({tag, " busy clear"}, 64'(busy), 64'd0);
    end else begin
      tick(); tick();
      check({tag, " valid held"}, 64'(xdiv_valid && ydiv_valid), 64'd1);
      check({tag, " busy in hold"}, 64'(busy), 64'd1);
      acc_done = 1'b0;
      tick();
      check({tag, " valid clear"}, 64'(xdiv_valid || ydiv_valid), 64'd0);
      check({tag, " busy clear"}, 64'(busy), 64'd0);
    end
    tick();
  endtask

  initial begin
    int issued, beats;
    bit bad;
    rst = 1'b1; acc_done = 1'b0; div_in_ready = 1'b1;
    sum_x = '0; sum_y = '0; count = '0;
    repeat (3) tick();
    check("rst xdiv", 64'(xdiv), 64'd0);
    check("rst ydiv", 64'(ydiv), 64'd0);
    check("rst flags", 64'({xdiv_valid, ydiv_valid, busy, zero_cnt, timeout, div_in_valid}), 64'd0);
    check("rst aresetn", 64'(div_aresetn), 64'd0);

    // acc_done rises while the divider is still held: must not start.
    rst = 1'b0; acc_done = 1'b1;
    #1 check("hold aresetn 0", 64'(div_aresetn), 64'd0);
    tick(); check("hold aresetn 1", 64'(div_aresetn), 64'd0);
    tick(); check("hold aresetn release", 64'(div_aresetn), 64'd1);
    tick(); tick();
    check("early edge ignored", 64'(busy), 64'd0);
    acc_done = 1'b0;
    tick();

    run_div("run1", 32'd6400, 32'd4000, 32'd20, 0, 1'b0, 32'd320, 32'd200);

    // Zero pixel count skips the divider and keeps the old quotients.
    sum_x = 32'd5; sum_y = 32'd5; count = 32'd0; acc_done = 1'b1;
    issued = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (div_in_valid) issued++;
    end
    check("zero no issue", 64'(issued), 64'd0);
    check("zero zero_cnt", 64'(zero_cnt), 64'd1);
    check("zero valids", 64'(xdiv_valid && ydiv_valid), 64'd1);
    check("zero xdiv kept", 64'(xdiv), 64'd320);
    check("zero ydiv kept", 64'(ydiv), 64'd200);
    acc_done = 1'b0;
    tick();
    check("zero clear", 64'({zero_cnt, xdiv_valid, busy}), 64'd0);
    tick();

    run_div("collect_fall", 32'd1000, 32'd35, 32'd7, 0, 1'b1, 32'd142, 32'd5);
    run_div("stall", 32'd6400, 32'd4000, 32'd20, 5, 1'b0, 32'd320, 32'd200);

`ifdef DIV_TIMEOUT_EN
    begin
      int tcyc = -1;
      model_en = 1'b0;
      sum_x = 32'd999; sum_y = 32'd888; count = 32'd3; acc_done = 1'b1;
      for (int i = 1; i < 100; i++) begin
        tick();
        if (timeout) begin tcyc = i; break; end
      end
      check("tmo cycle", 64'(tcyc), 64'(TMO + 1));
      check("tmo flush 0", 64'(div_aresetn), 64'd0);
      tick(); check("tmo flush 1", 64'(div_aresetn), 64'd0);
      tick(); check("tmo flush release", 64'(div_aresetn), 64'd1);
      check("tmo xdiv kept", 64'(xdiv), 64'd320);
      check("tmo ydiv kept", 64'(ydiv), 64'd200);
      tick(); tick();
      acc_done = 1'b0;
      tick();
      check("tmo clear", 64'({timeout, busy}), 64'd0);
      model_en = 1'b1;
      tick();
    end
`endif

    // Reset in COLLECT discards the run; the late beats must be ignored.
    sum_x = 32'd6400; sum_y = 32'd4000; count = 32'd20; acc_done = 1'b1;
    issued = 0;
    for (int i = 0; i < 20 && issued < 2; i++) begin
      tick();
      if (div_in_valid && div_in_ready) issued++;
    end
    check("mid issue", 64'(issued), 64'd2);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mid rst xdiv", 64'(xdiv), 64'd0);
    check("mid rst flags", 64'({xdiv_valid, busy, div_in_valid, div_aresetn}), 64'd0);
    tick();
    rst = 1'b0; acc_done = 1'b0;
    beats = 0; bad = 1'b0;
    tick(); check("mid aresetn 1", 64'(div_aresetn), 64'd0);
    tick(); check("mid aresetn release", 64'(div_aresetn), 64'd1);
    for (int i = 0; i < 15; i++) begin
      if (div_out_valid) beats++;
      if (xdiv != 0 || ydiv != 0 || xdiv_valid || busy) bad = 1'b1;
      tick();
    end
    check("late beats seen", 64'(beats), 64'd2);
    check("late beats ignored", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/centroid_div_sched.md
CENTROID_DIV_SCHED -- requirements
Module: centroid_div_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum wait in cycles for both quotients after the X issue.
REQ-002 SHALL have parameter MIN_COUNT, default 1, meaning the smallest pixel count treated as divisible.
REQ-003 SHALL have parameter RST_HOLD, default 2, meaning the number of cycles div_aresetn is held low after any divider reset request.
REQ-004 clk  in  1  the single clock; every register in the block is clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 acc_done  in  1  level; high means the accumulator frame totals are final.
REQ-007 sum_x, sum_y  in  32 each  accumulated coordinate sums, unsigned.
REQ-008 count  in  32  accumulated pixel count, unsigned.
REQ-009 div_dividend, div_divisor  out  32 each  divider operands.
REQ-010 div_in_valid  out  1  and div_in_ready  in  1  form the divider input handshake.
REQ-011 div_out_data  in  64  and div_out_valid  in  1  carry the divider result; the quotient is in bits [63:32].
REQ-012 div_aresetn  out  1  active-low divider reset.
REQ-013 xdiv, ydiv  out  32 each  registered quotients.
REQ-014 xdiv_valid, ydiv_valid  out  1 each  quotient-valid flags.
REQ-015 busy, zero_cnt, timeout  out  1 each  status flags.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ISSUE_X, ISSUE_Y, COLLECT, HOLD and FLUSH.
REQ-017 IDLE: on an acc_done rising edge (registered previous value 0, current 1), the block SHALL latch sum_x, sum_y and count, assert busy and go to ISSUE_X; an acc_done level already high when IDLE is entered SHALL NOT start a run.
REQ-018 If the latched count < MIN_COUNT, the block SHALL skip the divider, keep xdiv/ydiv unchanged, set zero_cnt, assert both valids and go to HOLD.
REQ-019 ISSUE_X SHALL drive dividend=sum_x, divisor=count and div_in_valid=1, and SHALL move to ISSUE_Y in the cycle div_in_ready=1; ISSUE_Y SHALL do the same with sum_y and then go to COLLECT.
REQ-020 Operands and div_in_valid SHALL stay stable while div_in_ready=0, and div_in_valid SHALL be 0 in every other state.
REQ-021 COLLECT: the first div_out_valid beat SHALL load xdiv and the second SHALL load ydiv, because results return in issue order.
REQ-022 COLLECT SHALL track beats with a 2-bit received counter, and a beat arriving in any state other than COLLECT SHALL be ignored.
REQ-023 On the second beat, xdiv_valid and ydiv_valid SHALL both assert in the next cycle, and the FSM SHALL go to HOLD.
REQ-024 HOLD: valids SHALL stay high while acc_done=1; when acc_done=0, valids, busy and zero_cnt SHALL clear and the FSM SHALL return to IDLE.
REQ-025 If acc_done is already 0 on entry to HOLD, the valids SHALL be high for exactly one cycle.
REQ-026 A fall of acc_done during ISSUE_X, ISSUE_Y or COLLECT SHALL NOT abort the run.
REQ-027 Latency SHALL be 1 cycle from the second result beat to the valids asserting.
REQ-028 FLUSH SHALL hold div_aresetn low for RST_HOLD cycles, discard all divider output, then go to HOLD.
REQ-029 Quotients SHALL be copied unmodified from div_out_data[63:32], with no scaling or saturation.

Reset
REQ-030 While rst=1, the FSM SHALL be IDLE and xdiv, ydiv, all valids, busy, zero_cnt, timeout and div_in_valid SHALL be 0.
REQ-031 div_aresetn SHALL be 0 while rst=1 and for RST_HOLD cycles after rst falls, then 1.
REQ-032 No acc_done edge SHALL be accepted before div_aresetn returns high.
REQ-033 A reset asserted mid-run SHALL discard the run entirely.

Configuration
REQ-034 With DIV_TIMEOUT_EN defined, a counter SHALL clear on entry to ISSUE_X and increment every cycle until HOLD.
REQ-035 With DIV_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL set timeout, keep the old xdiv/ydiv and go to FLUSH.
REQ-036 With DIV_TIMEOUT_EN defined, timeout SHALL clear together with the valids when HOLD exits.
REQ-037 Without DIV_TIMEOUT_EN, the counter and the FLUSH entry from timeout SHALL be absent, the block SHALL wait indefinitely, and timeout SHALL be tied to 0.

Structure
REQ-038 Package centroid_pkg SHALL hold the FSM state enum, the width constants (32 for data, 64 for divider results) and the quotient bit-slice constants.
REQ-039 The reset-hold counter SHALL be the sub-module div_rst_stretch, with inputs clk, rst and flush_req, parameter RST_HOLD, output div_aresetn and output ready.

Verification
REQ-040 Divider model with 8-cycle latency; sum_x=6400, sum_y=4000, count=20, acc_done rises -> xdiv=320, ydiv=200, both valids high 1 cycle after the 2nd beat, busy=1 throughout.
REQ-041 Same run with div_in_ready held low for 5 cycles during ISSUE_Y -> operands stay stable for those cycles, and the result still gives xdiv=320, ydiv=200.
REQ-042 count=0 -> no div_in_valid pulse, zero_cnt=1, valids high, xdiv/ydiv keep their previous values.
REQ-043 acc_done falls during COLLECT -> the run completes and the valids are high for exactly 1 cycle.
REQ-044 With DIV_TIMEOUT_EN defined and the divider never responding -> timeout=1 at cycle 64, div_aresetn low for 2 cycles, old quotients kept.
REQ-045 rst pulsed during COLLECT -> all outputs 0, a late divider beat is ignored, and div_aresetn stays low for 2 cycles after rst falls.
